obi_mem_responder: RTL and testbench

OBI_MEM_RESPONDER -- requirements
Module: obi_mem_responder

---
 rtl/obi_pkg.sv | 21 ++
 rtl/obi_resp_fifo.sv | 62 ++++++
 rtl/obi_mem_responder.sv | 124 ++++++++++++
 tb/tb_obi_mem_responder.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/obi_pkg.sv
// rtl/obi_pkg.sv - shared types and defaults for the OBI memory responder
package obi_pkg;

  localparam int OBI_DEPTH_WORDS_DEF     = 1024;
  localparam int OBI_GNT_WAIT_DEF        = 0;
  localparam int OBI_MAX_OUTSTANDING_DEF = 2;

  // One buffered response: read data plus error flag
  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } obi_resp_t;

  // Grant-side phase: no request, counting wait states, grant allowed
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_READY = 2'd2
  } obi_state_e;

endpackage

// File: rtl/obi_resp_fifo.sv
// rtl/obi_resp_fifo.sv - in-order response buffer holding obi_resp_t entries
module obi_resp_fifo
  import obi_pkg::*;
#(
  parameter int DEPTH = OBI_MAX_OUTSTANDING_DEF
) (
  input  logic      clk,
  input  logic      rst_i,
  input  logic      push_i,
  input  obi_resp_t push_data_i,
  input  logic      pop_i,
  output obi_resp_t head_o,
  output logic      empty_o,
  output logic      full_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [PW-1:0] LP_LAST = PW'(DEPTH - 1);

  obi_resp_t       r_mem [DEPTH];
  logic [PW-1:0]   r_wptr;
  logic [PW-1:0]   r_rptr;
  logic [CW-1:0]   r_count;
  logic            w_push;
  logic            w_pop;

  assign empty_o = (r_count == '0);
  assign full_o  = (r_count == CW'(DEPTH));
  assign w_push  = push_i && !full_o;
  assign w_pop   = pop_i && !empty_o;
  assign head_o  = r_mem[r_rptr];

  // Entry storage needs no reset; occupancy alone decides what is valid
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= push_data_i;
    end
  end

  // Pointers wrap explicitly so non-power-of-two depths work
  always_ff @(posedge clk) begin
    if (rst_i) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= (r_wptr == LP_LAST) ? '0 : r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= (r_rptr == LP_LAST) ? '0 : r_rptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/obi_mem_responder.sv
// rtl/obi_mem_responder.sv - OBI memory target with wait states and bounded outstanding responses
module obi_mem_responder
  import obi_pkg::*;
#(
  parameter int DEPTH_WORDS     = OBI_DEPTH_WORDS_DEF,
  parameter int GNT_WAIT        = OBI_GNT_WAIT_DEF,
  parameter int MAX_OUTSTANDING = OBI_MAX_OUTSTANDING_DEF
) (
  input  logic        clk,
  input  logic        rst_i,
  input  logic        req_i,
  input  logic [31:0] addr_i,
  input  logic        we_i,
  input  logic [3:0]  be_i,
  input  logic [31:0] wdata_i,
  input  logic        stall_i,
  output logic        gnt_o,
  output logic        rvalid_o,
  output logic [31:0] rdata_o,
  output logic        err_o
);

  localparam int          AW          = $clog2(DEPTH_WORDS);
  localparam logic [3:0]  LP_GNT_WAIT = 4'(GNT_WAIT);
  localparam logic [31:0] LP_LIMIT    = 32'(DEPTH_WORDS * 4);

  logic [31:0]   r_mem [DEPTH_WORDS];
  obi_state_e    r_state;
  obi_state_e    w_state_nxt;
  logic [3:0]    r_wait_cnt;
  logic [3:0]    w_wait_nxt;
  logic          w_ready;
  logic          w_gnt;
  logic          w_in_range;
  logic [AW-1:0] w_idx;
  logic          w_fifo_empty;
  logic          w_fifo_full;
  logic          w_rvalid;
  obi_resp_t     w_push_resp;
  obi_resp_t     w_head;

  assign w_idx      = addr_i[AW+1:2];
  assign w_in_range = (addr_i < LP_LIMIT);

  // Grant decision and wait-state sequencing; the counter restarts after every handshake
  always_comb begin
    w_ready     = (r_wait_cnt == LP_GNT_WAIT);
    w_gnt       = req_i && w_ready && !stall_i && !w_fifo_full && !rst_i;
    w_state_nxt = r_state;
    w_wait_nxt  = r_wait_cnt;
    if (!req_i || w_gnt) begin
      w_state_nxt = ST_IDLE;
      w_wait_nxt  = '0;
    end else begin
      case (r_state)
        ST_IDLE, ST_WAIT: begin
          if (w_ready) begin
            w_state_nxt = ST_READY;
          end else begin
            w_wait_nxt  = r_wait_cnt + 4'd1;
            w_state_nxt = (w_wait_nxt == LP_GNT_WAIT) ? ST_READY : ST_WAIT;
          end
        end
        ST_READY: w_state_nxt = ST_READY;
        default: begin
          w_state_nxt = ST_IDLE;
          w_wait_nxt  = '0;
        end
      endcase
    end
  end

  // Grant-side state register
  always_ff @(posedge clk) begin
    if (rst_i) begin
      r_state    <= ST_IDLE;
      r_wait_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_wait_cnt <= w_wait_nxt;
    end
  end

  // Response captured at acceptance: read data only for in-range reads
  always_comb begin
    w_push_resp       = '0;
    w_push_resp.err   = !w_in_range;
    if (w_in_range && !we_i) begin
      w_push_resp.rdata = r_mem[w_idx];
    end
  end

  // Byte-masked write; contents survive reset
  always_ff @(posedge clk) begin
    if (w_gnt && we_i && w_in_range) begin
      for (int b = 0; b < 4; b++) begin
        if (be_i[b]) begin
          r_mem[w_idx][8*b +: 8] <= wdata_i[8*b +: 8];
        end
      end
    end
  end

  obi_resp_fifo #(
    .DEPTH(MAX_OUTSTANDING)
  ) u_resp_fifo (
    .clk        (clk),
    .rst_i      (rst_i),
    .push_i     (w_gnt),
    .push_data_i(w_push_resp),
    .pop_i      (w_rvalid),
    .head_o     (w_head),
    .empty_o    (w_fifo_empty),
    .full_o     (w_fifo_full)
  );

  // No ready from the initiator: the head is presented and retired every cycle
  assign w_rvalid = !w_fifo_empty && !rst_i;
  assign gnt_o    = w_gnt;
  assign rvalid_o = w_rvalid;
  assign rdata_o  = w_rvalid ? w_head.rdata : 32'd0;
  assign err_o    = w_rvalid && w_head.err;

endmodule

// File: tb/tb_obi_mem_responder.sv
// tb/tb_obi_mem_responder.sv - randomized bench for obi_mem_responder against a transaction-level model
module tb_obi_mem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [2:0]  req;
  logic [2:0]  stall;
  logic [2:0]  gnt;
  logic [2:0]  rvalid;
  logic [2:0]  err;
  logic [31:0] rdata [3];
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        we;
  logic [3:0]  be;

  obi_mem_responder #(.DEPTH_WORDS(1024), .GNT_WAIT(0), .MAX_OUTSTANDING(2)) u_dut_a (
    .clk(clk), .rst_i(rst), .req_i(req[0]), .addr_i(addr), .we_i(we), .be_i(be),
    .wdata_i(wdata), .stall_i(stall[0]), .gnt_o(gnt[0]), .rvalid_o(rvalid[0]),
    .rdata_o(rdata[0]), .err_o(err[0]));

  obi_mem_responder #(.DEPTH_WORDS(16), .GNT_WAIT(3), .MAX_OUTSTANDING(2)) u_dut_b (
    .clk(clk), .rst_i(rst), .req_i(req[1]), .addr_i(addr), .we_i(we), .be_i(be),
    .wdata_i(wdata), .stall_i(stall[1]), .gnt_o(gnt[1]), .rvalid_o(rvalid[1]),
    .rdata_o(rdata[1]), .err_o(err[1]));

  obi_mem_responder #(.DEPTH_WORDS(16), .GNT_WAIT(0), .MAX_OUTSTANDING(1)) u_dut_c (
    .clk(clk), .rst_i(rst), .req_i(req[2]), .addr_i(addr), .we_i(we), .be_i(be),
    .wdata_i(wdata), .stall_i(stall[2]), .gnt_o(gnt[2]), .rvalid_o(rvalid[2]),
    .rdata_o(rdata[2]), .err_o(err[2]));

  int depth_m [3] = '{1024, 16, 16};
  int gw_m    [3] = '{0, 3, 0};
  int mo_m    [3] = '{2, 2, 1};

  int          n_total = 0;
  int          n_bad   = 0;
  logic [31:0] mm [3][1024];
  logic [32:0] eq0 [$];
  logic [32:0] eq1 [$];
  logic [32:0] eq2 [$];
  int          req_run [3] = '{0, 0, 0};
  int          resp_cnt [3] = '{0, 0, 0};
  logic [31:0] last_rdata [3];
  logic        last_err [3];

  task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=0x%08h exp=0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int eq_size(input int d);
    case (d)
      0:       return eq0.size();
      1:       return eq1.size();
      default: return eq2.size();
    endcase
  endfunction

  task automatic eq_push(input int d, input logic [32:0] v);
    case (d)
      0:       eq0.push_back(v);
      1:       eq1.push_back(v);
      default: eq2.push_back(v);
    endcase
  endtask

  task automatic eq_pop(input int d, output logic [32:0] v);
    case (d)
      0:       v = eq0.pop_front();
      1:       v = eq1.pop_front();
      default: v = eq2.pop_front();
    endcase
  endtask

  task automatic eq_clear(input int d);
    case (d)
      0:       eq0.delete();
      1:       eq1.delete();
      default: eq2.delete();
    endcase
  endtask

  // Model of one target for the current cycle: grant rule, head-of-queue response, then acceptance
  task automatic mon(input int d);
    int          occ;
    int          widx;
    logic        exp_g;
    logic [32:0] h;
    occ   = eq_size(d);
    exp_g = req[d] && !stall[d] && !rst && (req_run[d] >= gw_m[d]) && (occ < mo_m[d]);
    expect_eq($sformatf("gnt[%0d]", d), 32'(gnt[d]), 32'(exp_g));
    if (!rst && occ > 0) begin
      eq_pop(d, h);
      expect_eq($sformatf("rvalid[%0d]", d), 32'(rvalid[d]), 32'd1);
      expect_eq($sformatf("rdata[%0d]", d), rdata[d], h[32:1]);
      expect_eq($sformatf("err[%0d]", d), 32'(err[d]), 32'(h[0]));
      last_rdata[d] = rdata[d];
      last_err[d]   = err[d];
      resp_cnt[d]++;
    end else begin
      expect_eq($sformatf("idle_rvalid[%0d]", d), 32'(rvalid[d]), 32'd0);
      expect_eq($sformatf("idle_rdata[%0d]", d), rdata[d], 32'd0);
      expect_eq($sformatf("idle_err[%0d]", d), 32'(err[d]), 32'd0);
    end
    if (rst) eq_clear(d);
    if (!rst && req[d] && gnt[d]) begin
      if (64'(addr) >= 64'(depth_m[d]) * 64'd4) begin
        h = {32'd0, 1'b1};
      end else begin
        widx = int'(addr >> 2);
        if (we) begin
          for (int b = 0; b < 4; b++) begin
            if (be[b]) mm[d][widx][8*b +: 8] = wdata[8*b +: 8];
          end
          h = 33'd0;
        end else begin
          h = {mm[d][widx], 1'b0};
        end
      end
      eq_push(d, h);
    end
    if (rst || !req[d] || gnt[d]) req_run[d] = 0;
    else req_run[d]++;
  endtask

  task automatic half();
    @(negedge clk);
    for (int d = 0; d < 3; d++) mon(d);
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc();
    half();
    adv();
  endtask

  task automatic idle(input int n);
    req   = '0;
    stall = '0;
    repeat (n) cyc();
  endtask

  // Present one request and hold it until granted; req stays high afterwards for back-to-back use
  task automatic issue(input int d, input logic we_v, input logic [31:0] a, input logic [3:0] b,
                       input logic [31:0] w, input logic rstall, output int waits);
    logic done;
    req      = '0;
    req[d]   = 1'b1;
    we       = we_v;
    addr     = a;
    be       = b;
    wdata    = w;
    stall    = '0;
    stall[d] = rstall && ($urandom_range(0, 3) == 0);
    waits    = 0;
    done     = 1'b0;
    while (!done) begin
      half();
      if (gnt[d]) begin
        done = 1'b1;
      end else begin
        waits++;
        if (waits > 64) begin
          expect_eq("gnt_timeout", 32'(waits), 32'd0);
          done = 1'b1;
        end
      end
      adv();
      if (!done) stall[d] = rstall && ($urandom_range(0, 3) == 0);
    end
    stall = '0;
  endtask

  initial begin
    int          w;
    int          w2;
    int          w3;
    int          c0;
    int          lim;
    logic [31:0] a;

    rst = 1'b1; req = '0; stall = '0; we = 1'b0; addr = '0; be = 4'hF; wdata = '0;
    adv();
    req = 3'b001; we = 1'b1; addr = 32'h0; wdata = 32'h0BAD_F00D;
    half();
    expect_eq("rst_gnt", 32'(gnt[0]), 32'd0);
    expect_eq("rst_rvalid", 32'(rvalid[0]), 32'd0);
    adv();
    cyc();
    rst = 1'b0;
    issue(0, 1'b1, 32'h0, 4'hF, 32'h0BAD_F00D, 1'b0, w);
    expect_eq("first_after_reset_waits", 32'(w), 32'd0);

    for (int i = 1; i < 64; i++) issue(0, 1'b1, 32'(i * 4), 4'hF, $urandom, 1'b0, w);
    idle(1);
    for (int d = 1; d < 3; d++) begin
      for (int i = 0; i < 16; i++) issue(d, 1'b1, 32'(i * 4), 4'hF, $urandom, 1'b0, w);
      idle(1);
    end

    idle(2);
    issue(0, 1'b1, 32'h10, 4'hF, 32'hDEAD_BEEF, 1'b0, w);
    expect_eq("wr_gnt_same_cycle", 32'(w), 32'd0);
    issue(0, 1'b0, 32'h10, 4'hF, 32'h0, 1'b0, w);
    expect_eq("rd_gnt_same_cycle", 32'(w), 32'd0);
    idle(2);
    expect_eq("rd_deadbeef", last_rdata[0], 32'hDEAD_BEEF);
    expect_eq("rd_deadbeef_err", 32'(last_err[0]), 32'd0);

    issue(0, 1'b1, 32'h20, 4'hF, 32'h1122_3344, 1'b0, w);
    issue(0, 1'b1, 32'h20, 4'b0101, 32'hAABB_CCDD, 1'b0, w);
    issue(0, 1'b0, 32'h20, 4'hF, 32'h0, 1'b0, w);
    idle(2);
    expect_eq("byte_enable_merge", last_rdata[0], 32'h11BB_33DD);

    issue(0, 1'b1, 32'h1000, 4'hF, 32'hFFFF_FFFF, 1'b0, w);
    idle(2);
    expect_eq("oor_err", 32'(last_err[0]), 32'd1);
    expect_eq("oor_rdata", last_rdata[0], 32'd0);
    issue(0, 1'b0, 32'h0, 4'hF, 32'h0, 1'b0, w);
    idle(2);
    expect_eq("oor_word0_intact", last_rdata[0], 32'h0BAD_F00D);

    issue(1, 1'b0, 32'h4, 4'hF, 32'h0, 1'b0, w);
    expect_eq("wait3_gnt_4th_cycle", 32'(w), 32'd3);
    idle(1);
    req = 3'b010; we = 1'b0; addr = 32'h8; stall[1] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      half();
      expect_eq("stall_no_gnt", 32'(gnt[1]), 32'd0);
      adv();
    end
    stall[1] = 1'b0;
    half();
    expect_eq("gnt_at_stall_fall", 32'(gnt[1]), 32'd1);
    adv();
    idle(2);

    c0 = resp_cnt[2];
    issue(2, 1'b0, 32'h4, 4'hF, 32'h0, 1'b0, w);
    issue(2, 1'b0, 32'h8, 4'hF, 32'h0, 1'b0, w2);
    issue(2, 1'b0, 32'hC, 4'hF, 32'h0, 1'b0, w3);
    idle(3);
    expect_eq("full_first_waits", 32'(w), 32'd0);
    expect_eq("full_second_waits", 32'(w2), 32'd1);
    expect_eq("full_third_waits", 32'(w3), 32'd1);
    expect_eq("full_resp_count", 32'(resp_cnt[2] - c0), 32'd3);

    issue(0, 1'b0, 32'h10, 4'hF, 32'h0, 1'b0, w);
    issue(0, 1'b0, 32'h20, 4'hF, 32'h0, 1'b0, w);
    rst = 1'b1; req = '0;
    half();
    expect_eq("rst_drop_rvalid", 32'(rvalid[0]), 32'd0);
    adv();
    half();
    expect_eq("rst_hold_rvalid", 32'(rvalid[0]), 32'd0);
    adv();
    rst = 1'b0;
    c0 = resp_cnt[0];
    issue(0, 1'b0, 32'h10, 4'hF, 32'h0, 1'b0, w);
    idle(2);
    expect_eq("post_rst_rdata", last_rdata[0], 32'hDEAD_BEEF);
    expect_eq("post_rst_resp_count", 32'(resp_cnt[0] - c0), 32'd1);

    for (int d = 0; d < 3; d++) begin
      lim = (d == 0) ? 64 : 16;
      for (int n = 0; n < 150; n++) begin
        if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 2)));
        if ($urandom_range(0, 7) == 0) begin
          a = ($urandom_range(0, 1) == 1) ? (32'(depth_m[d] * 4) + 32'($urandom_range(0, 255)))
                                           : ($urandom | 32'h8000_0000);
        end else begin
          a = 32'($urandom_range(0, lim - 1)) * 32'd4 + 32'($urandom_range(0, 3));
        end
        issue(d, 1'($urandom_range(0, 1)), a, 4'($urandom_range(0, 15)), $urandom, 1'b1, w);
      end
      idle(3);
    end

    idle(3);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
